instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Program-counter and fetch stage feeding the combinational instruction memory.
//  Drives the read address, captures the returned word into an IF/ID output
//  register with a valid/ready handshake, and handles stalls, branch redirects
//  (flush) and a HALT opcode. Sits between instruction memory and the decoder.
// PARAMETERS
//  DATA_WIDTH     20     instruction width, matches instruction memory
//  ADDRESS_WIDTH  8      PC / memory address width
//  MEM_SIZE       256    number of valid instruction words
//  RESET_PC       0      PC loaded on reset
//  HALT_OPCODE    4'hF   value of instr[DATA_WIDTH-1 -: 4] that halts fetching
// PORTS
//  clk             in   1              clock, all state updates on rising edge
//  rst_n           in   1              synchronous, active-low reset
//  start           in   1              IDLE->FETCH request
//  imem_addr       out  ADDRESS_WIDTH  read address to instruction memory (= pc register)
//  imem_data       in   DATA_WIDTH     combinational read data from instruction memory
//  redirect_valid  in   1              branch/jump taken, 1-cycle pulse
//  redirect_pc     in   ADDRESS_WIDTH  redirect target
//  id_ready        in   1              decoder accepts id_instr this cycle
//  id_valid        out  1              id_instr/id_pc hold a valid instruction
//  id_instr        out  DATA_WIDTH     fetched instruction
//  id_pc           out  ADDRESS_WIDTH  address the instruction was fetched from
//  halted          out  1              high while in HALTED
//  fault           out  1              PC out of range (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, pc=RESET_PC, id_valid=0, id_instr=0,
//    id_pc=0, halted=0, fault=0. Reset has priority over all inputs, mid-operation too.
//  - States: IDLE, FETCH, HALTED (+FAULT with macro). imem_addr=pc in every state.
//  - IDLE: outputs held; start=1 -> FETCH next cycle. redirect_valid ignored.
//  - FETCH, slot free (id_valid=0 or id_ready=1): id_instr<=imem_data, id_pc<=pc,
//    id_valid<=1, pc<=pc+1. Latency: word at A on id_instr 1 cycle after pc==A.
//  - FETCH, stall (id_valid=1 and id_ready=0): pc, id_* all held unchanged.
//  - Handshake: transfer when id_valid&id_ready at edge; id_valid never drops without
//    transfer except on redirect or reset.
//  - Redirect (FETCH or HALTED): highest priority after reset. pc<=redirect_pc,
//    id_valid<=0 (flush incl. stalled word), state<=FETCH. Redirect target word appears
//    on id_instr 2 cycles after the redirect pulse.
//  - HALT: when captured imem_data[DATA_WIDTH-1 -: 4]==HALT_OPCODE, it is presented
//    normally and state<=HALTED same edge; pc frozen at halt address+1; no further
//    capture; id_valid clears after its transfer; halted=1 while in HALTED.
//  - pc arithmetic: ADDRESS_WIDTH bits, +1 modulo 2**ADDRESS_WIDTH.
//  - Simultaneous redirect + halt capture: redirect wins, halt word discarded.
// CONFIGURATION
//  PC_BOUNDS_CHECK_EN defined: if pc>=MEM_SIZE while FETCH with slot free, no
//    capture, state<=FAULT, fault<=1 (sticky until reset); FAULT ignores redirect.
//  Not defined: no FAULT state, fault tied 0, pc wraps 2**ADDRESS_WIDTH-1 -> 0.
// TESTING
//  1 reset, start; mem[0..2]=0x12345,0x0ABCD,0x00001, id_ready=1 -> id_instr sequence
//    0x12345/0x0ABCD/0x00001 on consecutive cycles, id_pc 0,1,2.
//  2 id_ready=0 for 3 cycles with id_instr=0x0ABCD -> id_*, imem_addr stable; resumes
//    with 0x00001 next cycle after id_ready=1.
//  3 redirect_valid pulse, redirect_pc=0x40 while stalled -> id_valid=0 next cycle,
//    id_instr=mem[0x40], id_pc=0x40 on following cycle.
//  4 mem[5]=0xF0000 -> presented with id_pc=5, halted=1, pc frozen at 6; redirect to 0
//    restarts fetch, halted=0.
//  5 rst_n=0 one cycle mid-stream -> all outputs reset values, IDLE until start.
//  6 MEM_SIZE=16, redirect to 0x0F: with PC_BOUNDS_CHECK_EN fault=1 after word 15;
//    without, pc reaches 0x10 and continues fetching, fault=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC and fetch stage with IF/ID valid/ready output register
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 leave IDLE and begin fetching
//   imem_addr/imem_data   address to / combinational data from instruction memory
//   redirect_valid/_pc    branch redirect pulse and target (flushes the IF/ID slot)
//   id_valid/id_ready     handshake with the decoder for id_instr/id_pc
//   halted                high while in HALTED (HALT opcode fetched)
//   fault                 PC out of range (only with PC_BOUNDS_CHECK_EN, else tied 0)
//
// Optional feature macro: PC_BOUNDS_CHECK_EN adds a sticky FAULT state entered when
// the PC reaches MEM_SIZE while a fetch would be issued.
module instruction_fetch_unit #(
    parameter int                DATA_WIDTH    = 20,
    parameter int                ADDRESS_WIDTH = 8,
    parameter int                MEM_SIZE      = 256,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OPCODE   = 4'hF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_data,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [DATA_WIDTH-1:0]    id_instr,
    output logic [ADDRESS_WIDTH-1:0] id_pc,
    output logic                     halted,
    output logic                     fault
);

`ifdef PC_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED, S_FAULT} state_t;
    localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE);
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;
`endif

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] pc;

    // The IF/ID slot can take a new word if it is empty or being drained this cycle.
    logic slot_free;
    logic transfer;
    logic is_halt;

    assign slot_free = !id_valid || id_ready;
    assign transfer  = id_valid && id_ready;
    assign is_halt   = (imem_data[DATA_WIDTH-1 -: 4] == HALT_OPCODE);
    assign imem_addr = pc;

`ifdef PC_BOUNDS_CHECK_EN
    logic pc_out_of_range;
    assign pc_out_of_range = ({1'b0, pc} >= MEM_LIMIT);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        id_valid <= 1'b0;
                    end else if (slot_free) begin
`ifdef PC_BOUNDS_CHECK_EN
                        if (pc_out_of_range) begin
                            // No capture; a word still being handed over drains normally.
                            state    <= S_FAULT;
                            fault    <= 1'b1;
                            id_valid <= 1'b0;
                        end else begin
`endif
                            id_instr <= imem_data;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            pc       <= pc + 1'b1;
                            // The HALT word itself is still presented to the decoder.
                            if (is_halt) begin
                                state  <= S_HALTED;
                                halted <= 1'b1;
                            end
`ifdef PC_BOUNDS_CHECK_EN
                        end
`endif
                    end
                end

                S_HALTED: begin
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        id_valid <= 1'b0;
                        state    <= S_FETCH;
                        halted   <= 1'b0;
                    end else if (transfer) begin
                        id_valid <= 1'b0;
                    end
                end

`ifdef PC_BOUNDS_CHECK_EN
                S_FAULT: begin
                    // Sticky until reset; redirects are deliberately ignored here.
                    if (transfer) begin
                        id_valid <= 1'b0;
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [19:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [19:0] id_instr;
    logic [7:0]  id_pc;
    logic        halted;
    logic        fault;

    logic [19:0] mem [256];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch_unit #(
        .DATA_WIDTH   (20),
        .ADDRESS_WIDTH(8),
        .MEM_SIZE     (16),
        .RESET_PC     (8'h00),
        .HALT_OPCODE  (4'hF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .halted        (halted),
        .fault         (fault)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [7:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; id_ready = 1'b1;
        tick(); tick();
        n_cmp++; if ({id_valid, halted, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {id_valid, halted, fault}); end
        n_cmp++; if (id_instr !== 20'h0) begin n_fail++; $display("FAIL reset_instr got %h want 00000", id_instr); end
        n_cmp++; if ({imem_addr, id_pc} !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h want 0000", {imem_addr, id_pc}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_start got %b want 0", id_valid); end
    endtask

    task automatic test_sequential_fetch();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h12345, 8'h00}) begin n_fail++; $display("FAIL seq_w0 got %b/%h/%h want 1/12345/00", id_valid, id_instr, id_pc); end
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h0ABCD, 8'h01}) begin n_fail++; $display("FAIL seq_w1 got %b/%h/%h want 1/0abcd/01", id_valid, id_instr, id_pc); end
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h00001, 8'h02}) begin n_fail++; $display("FAIL seq_w2 got %b/%h/%h want 1/00001/02", id_valid, id_instr, id_pc); end
        n_cmp++; if (imem_addr !== 8'h03) begin n_fail++; $display("FAIL seq_addr got %h want 03", imem_addr); end
    endtask

    task automatic test_stall();
        pulse_redirect(8'h01);
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_flush got %b want 0", id_valid); end
        tick();
        n_cmp++; if ({id_instr, id_pc} !== {20'h0ABCD, 8'h01}) begin n_fail++; $display("FAIL stall_pre got %h/%h want 0abcd/01", id_instr, id_pc); end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({id_valid, id_instr, id_pc, imem_addr} !== {1'b1, 20'h0ABCD, 8'h01, 8'h02}) begin n_fail++; $display("FAIL stall_hold%0d got %b/%h/%h/%h want 1/0abcd/01/02", i, id_valid, id_instr, id_pc, imem_addr); end
        end
        id_ready = 1'b1;
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h00001, 8'h02}) begin n_fail++; $display("FAIL stall_resume got %b/%h/%h want 1/00001/02", id_valid, id_instr, id_pc); end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        tick();
        pulse_redirect(8'h40);
        n_cmp++; if ({id_valid, imem_addr} !== {1'b0, 8'h40}) begin n_fail++; $display("FAIL redir_flush got %b/%h want 0/40", id_valid, imem_addr); end
        id_ready = 1'b1;
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h00040, 8'h40}) begin n_fail++; $display("FAIL redir_word got %b/%h/%h want 1/00040/40", id_valid, id_instr, id_pc); end
    endtask

    task automatic test_halt();
        pulse_redirect(8'h04);
        tick();
        n_cmp++; if ({id_instr, id_pc, halted} !== {20'h00003, 8'h04, 1'b0}) begin n_fail++; $display("FAIL halt_pre got %h/%h/%b want 00003/04/0", id_instr, id_pc, halted); end
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc, halted, imem_addr} !== {1'b1, 20'hF0000, 8'h05, 1'b1, 8'h06}) begin n_fail++; $display("FAIL halt_word got %b/%h/%h/%b/%h want 1/f0000/05/1/06", id_valid, id_instr, id_pc, halted, imem_addr); end
        tick();
        n_cmp++; if ({id_valid, halted, imem_addr} !== {1'b0, 1'b1, 8'h06}) begin n_fail++; $display("FAIL halt_drain got %b/%b/%h want 0/1/06", id_valid, halted, imem_addr); end
        tick();
        n_cmp++; if ({id_valid, halted, imem_addr} !== {1'b0, 1'b1, 8'h06}) begin n_fail++; $display("FAIL halt_frozen got %b/%b/%h want 0/1/06", id_valid, halted, imem_addr); end
        pulse_redirect(8'h00);
        n_cmp++; if ({id_valid, halted, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL halt_restart got %b/%b/%h want 0/0/00", id_valid, halted, imem_addr); end
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h12345, 8'h00}) begin n_fail++; $display("FAIL halt_refetch got %b/%h/%h want 1/12345/00", id_valid, id_instr, id_pc); end
    endtask

    task automatic test_mid_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if ({id_valid, id_instr, id_pc, halted, fault, imem_addr} !== {1'b1 ^ 1'b1, 20'h0, 8'h0, 1'b0, 1'b0, 8'h0}) begin n_fail++; $display("FAIL midrst_out got %b/%h/%h/%b/%b/%h want 0/00000/00/0/0/00", id_valid, id_instr, id_pc, halted, fault, imem_addr); end
        tick(); tick();
        n_cmp++; if ({id_valid, imem_addr} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL midrst_idle got %b/%h want 0/00", id_valid, imem_addr); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h12345, 8'h00}) begin n_fail++; $display("FAIL midrst_restart got %b/%h/%h want 1/12345/00", id_valid, id_instr, id_pc); end
    endtask

    task automatic test_pc_bounds();
        pulse_redirect(8'h0F);
        tick();
        n_cmp++; if ({id_instr, id_pc, fault} !== {20'h0000F, 8'h0F, 1'b0}) begin n_fail++; $display("FAIL bound_w15 got %h/%h/%b want 0000f/0f/0", id_instr, id_pc, fault); end
`ifdef PC_BOUNDS_CHECK_EN
        tick();
        n_cmp++; if ({id_valid, fault} !== 2'b01) begin n_fail++; $display("FAIL bound_fault got %b/%b want 0/1", id_valid, fault); end
        pulse_redirect(8'h00);
        n_cmp++; if ({id_valid, fault, imem_addr} !== {1'b0, 1'b1, 8'h10}) begin n_fail++; $display("FAIL bound_sticky got %b/%b/%h want 0/1/10", id_valid, fault, imem_addr); end
`else
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc, fault} !== {1'b1, 20'h00010, 8'h10, 1'b0}) begin n_fail++; $display("FAIL bound_w16 got %b/%h/%h/%b want 1/00010/10/0", id_valid, id_instr, id_pc, fault); end
        pulse_redirect(8'hFF);
        tick();
        n_cmp++; if ({id_instr, id_pc, imem_addr} !== {20'h000FF, 8'hFF, 8'h00}) begin n_fail++; $display("FAIL wrap_ff got %h/%h/%h want 000ff/ff/00", id_instr, id_pc, imem_addr); end
        tick();
        n_cmp++; if ({id_valid, id_instr, id_pc} !== {1'b1, 20'h12345, 8'h00}) begin n_fail++; $display("FAIL wrap_0 got %b/%h/%h want 1/12345/00", id_valid, id_instr, id_pc); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 20'(i);
        mem[0] = 20'h12345; mem[1] = 20'h0ABCD; mem[2] = 20'h00001;
        mem[3] = 20'h00002; mem[4] = 20'h00003; mem[5] = 20'hF0000;
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect();
        test_halt();
        test_mid_reset();
        test_pc_bounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
